// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, default baud divisor,
// and serial line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // 115200 baud from a 50 MHz clock
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    localparam logic MARK  = 1'b1;
    localparam logic SPACE = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period timer: tick is high on the last cycle of every bit period.
// A synchronous clear holds the count at zero so a frame can restart the period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic s_reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (s_reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, LSB-first data, optional even parity, stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 s_reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state, state_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [2:0]           idx, idx_next;
    logic                 stop_cnt, stop_next;
    logic                 tx_next;
    logic                 done_next;
    logic                 tick;
    logic                 clear;

    // Timer only runs inside a frame, so every frame starts on a fresh bit period.
    assign clear = (state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .s_reset(s_reset),
        .clear  (clear),
        .tick   (tick)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk) begin
        if (state == IDLE && tx_valid) begin
            parity_bit <= ^tx_data;
        end
    end
`endif

    always_comb begin
        state_next = state;
        shift_next = shift;
        idx_next   = idx;
        stop_next  = stop_cnt;
        tx_next    = tx;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                tx_next = MARK;
                if (tx_valid) begin
                    state_next = START;
                    shift_next = tx_data;
                    idx_next   = '0;
                    stop_next  = 1'b0;
                    tx_next    = SPACE;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                    shift_next = shift >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_bit;
`else
                        state_next = STOP;
                        tx_next    = MARK;
`endif
                    end else begin
                        tx_next    = shift[0];
                        shift_next = shift >> 1;
                        idx_next   = idx + 3'd1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (tick) begin
                    state_next = STOP;
                    tx_next    = MARK;
                end
`else
                state_next = IDLE;
                tx_next    = MARK;
`endif
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        stop_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = MARK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            state    <= IDLE;
            idx      <= '0;
            stop_cnt <= 1'b0;
            tx       <= MARK;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            stop_cnt <= stop_next;
            tx       <= tx_next;
            tx_done  <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: the driver queues expected frames, a line monitor
// recovers frames from tx and compares bit levels and the tx_done pulse.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FLEN = 1 + DB + PB + SB;

    logic          clk      = 1'b0;
    logic          s_reset  = 1'b1;
    logic [DB-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx;
    logic          busy;
    logic          tx_done;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .STOP_BITS   (SB)
    ) dut (
        .clk     (clk),
        .s_reset (s_reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    int checks      = 0;
    int passes      = 0;
    int frames_done = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Line levels in transmit order: start, data LSB first, parity, stop bits.
    function automatic logic [15:0] frame_bits(input logic [DB-1:0] d);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1+i] = d[i];
        if (PB == 1) f[1+DB] = ^d;
        return f;
    endfunction

    // Monitor: a frame begins at the first low sample on the line.
    initial begin : monitor
        logic [15:0] f;
        bit ok;
        bit aborted;
        forever begin
            @(negedge clk);
            if (s_reset !== 1'b0 || tx !== 1'b0) continue;
            check(exp_q.size() != 0, "frame_expected", exp_q.size(), 1);
            if (exp_q.size() == 0) begin
                repeat (FLEN * CPB) @(negedge clk);
                continue;
            end
            f = exp_q.pop_front();
            aborted = 1'b0;
            for (int b = 0; b < FLEN && !aborted; b++) begin
                ok = 1'b1;
                for (int c = 0; c < CPB && !aborted; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (s_reset === 1'b1) aborted = 1'b1;
                    else if (tx !== f[b] || tx_done !== 1'b0 || tx_ready !== 1'b0) ok = 1'b0;
                end
                if (!aborted)
                    check(ok, $sformatf("frame%0d_bit%0d", frames_done, b), {31'd0, tx}, {31'd0, f[b]});
            end
            if (!aborted) begin
                @(negedge clk);
                check(tx_done === 1'b1 && tx_ready === 1'b1 && tx === 1'b1, "done_pulse",
                      {29'd0, tx_done, tx_ready, tx}, 32'h7);
                frames_done++;
            end
        end
    end

    task automatic send(input logic [DB-1:0] d, output bit done_at_accept);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(tx_ready === 1'b1, "accept_ready", {31'd0, tx_ready}, 1);
        done_at_accept = tx_done;
        exp_q.push_back(frame_bits(d));
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (tx_done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin : driver
        bit dflag;
        bit seen;
        int n;
        int f0;

        repeat (3) @(posedge clk);
        #1;
        check(tx === 1'b1,       "reset_tx",    {31'd0, tx},       1);
        check(tx_ready === 1'b1, "reset_ready", {31'd0, tx_ready}, 1);
        check(busy === 1'b0,     "reset_busy",  {31'd0, busy},     0);
        check(tx_done === 1'b0,  "reset_done",  {31'd0, tx_done},  0);
        s_reset = 1'b0;

        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (dut.tick !== 1'b0 || tx !== 1'b1) seen = 1'b1;
        end
        check(!seen, "idle_no_tick", {31'd0, seen}, 0);
        @(posedge clk); #1;

        // 0xA5 and accept-to-done latency
        send(8'hA5, dflag);
        wait_done(n);
        check(n == FLEN * CPB, "a5_latency", n, FLEN * CPB);

        // back-to-back: second accept lands in the tx_done cycle
        send(8'h00, dflag);
        send(8'hFF, dflag);
        check(dflag == 1'b1, "b2b_accept_in_done_cycle", {31'd0, dflag}, 1);
        check(tx === 1'b0, "b2b_start_follows", {31'd0, tx}, 0);
        wait_done(n);
        check(n == FLEN * CPB, "ff_latency", n, FLEN * CPB);

        // tx_valid pulse mid-frame must be ignored
        @(posedge clk); #1;
        f0 = frames_done;
        send(8'hC3, dflag);
        repeat (12) @(posedge clk);
        #1;
        check(busy === 1'b1, "busy_mid_frame", {31'd0, busy}, 1);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_done(n);
        check(n == FLEN * CPB - 13, "c3_latency", n, FLEN * CPB - 13);
        repeat (3 * FLEN * CPB) @(posedge clk);
        #1;
        check(frames_done == f0 + 1, "ignore_no_extra_frame", frames_done, f0 + 1);

        // reset during data bit 3 aborts the frame
        send(8'hF0, dflag);
        repeat (17) @(posedge clk);
        #1;
        s_reset = 1'b1;
        @(posedge clk); #1;
        s_reset = 1'b0;
        check(tx === 1'b1 && tx_ready === 1'b1, "abort_line_idle", {30'd0, tx, tx_ready}, 3);
        seen = 1'b0;
        repeat (FLEN * CPB) begin
            @(negedge clk);
            if (tx_done !== 1'b0) seen = 1'b1;
        end
        check(!seen, "abort_no_done", {31'd0, seen}, 0);
        @(posedge clk); #1;
        send(8'h55, dflag);
        wait_done(n);
        check(n == FLEN * CPB, "55_latency", n, FLEN * CPB);

`ifdef UART_TX_PARITY_EN
        @(posedge clk); #1;
        send(8'h07, dflag);
        wait_done(n);
        check(n == 44, "par07_latency", n, 44);
        @(posedge clk); #1;
        send(8'h03, dflag);
        wait_done(n);
        check(n == 44, "par03_latency", n, 44);
`endif

        repeat (5) @(posedge clk);
        #1;
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
